// File: rtl/core_ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word
// and default reset vector.
package core_ifetch_pkg;

  localparam logic [1:0] IF_IDLE = 2'd0;
  localparam logic [1:0] IF_ADDR = 2'd1;
  localparam logic [1:0] IF_DATA = 2'd2;
  localparam logic [1:0] IF_DONE = 2'd3;

  localparam logic [31:0] IF_NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = IF_IDLE,
    ST_ADDR = IF_ADDR,
    ST_DATA = IF_DATA,
    ST_DONE = IF_DONE
  } if_state_t;

endpackage

// File: rtl/core_ifetch.sv
// Instruction-fetch stage: owns the PC, issues one read at a time on a
// valid/ready port and discards responses made stale by a PC redirect.
module core_ifetch
  import core_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = IF_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = IF_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [31:0] PC_NEXT,
  input  logic        PC_WRITE,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        IMEM_BUSY,
  output logic        IMEM_DONE,
  output logic        FETCH_ERR,
  output logic        IMEM_ARVALID,
  output logic [31:0] IMEM_ARADDR,
  input  logic        IMEM_ARREADY,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_RERR
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  if_state_t   state, state_n;
  logic        kill, kill_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] instr, instr_n;
  logic        err, err_n;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state    <= ST_IDLE;
      kill     <= 1'b0;
      pc       <= RESET_VECTOR & ALIGN_MASK;
      req_addr <= RESET_VECTOR & ALIGN_MASK;
      instr    <= NOP_INSTR;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      kill     <= kill_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      instr    <= instr_n;
      err      <= err_n;
    end
  end

  // A redirect during ADDR or DATA cannot cancel the bus transaction, so it
  // only arms kill; the outstanding response is then dropped on arrival.
  always_comb begin
    state_n    = state;
    kill_n     = kill;
    pc_n       = pc;
    req_addr_n = req_addr;
    instr_n    = instr;
    err_n      = err;

    if (PC_WRITE) pc_n = PC_NEXT & ALIGN_MASK;

    case (state)
      ST_IDLE: state_n = ST_ADDR;
      ST_ADDR: begin
        if (PC_WRITE) kill_n = 1'b1;
        if (IMEM_ARREADY) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (IMEM_RVALID) begin
          if (PC_WRITE || kill) begin
            kill_n  = 1'b0;
            state_n = ST_ADDR;
          end else begin
            instr_n = IMEM_RERR ? NOP_INSTR : IMEM_RDATA;
            err_n   = IMEM_RERR;
            state_n = ST_DONE;
          end
        end else if (PC_WRITE) begin
          kill_n = 1'b1;
        end
      end
      ST_DONE: if (PC_WRITE) state_n = ST_ADDR;
      default: state_n = ST_IDLE;
    endcase

    // The request address is latched on entry to ADDR so it stays stable
    // until the handshake even if the PC is redirected meanwhile.
    if (state_n == ST_ADDR && state != ST_ADDR) req_addr_n = pc_n;
  end

  assign PC           = pc;
  assign INSTRUCTION  = instr;
  assign FETCH_ERR    = err;
  assign IMEM_ARVALID = (state == ST_ADDR);
  assign IMEM_ARADDR  = req_addr;
  assign IMEM_BUSY    = (state == ST_ADDR) || (state == ST_DATA);
  assign IMEM_DONE    = (state == ST_DONE);

endmodule

// File: tb/tb_core_ifetch.sv
// Directed, table-driven bench for core_ifetch with one latency sequence.
module tb_core_ifetch;

  logic        CLK;
  logic        NRST;
  logic [31:0] PC_NEXT;
  logic        PC_WRITE;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        IMEM_BUSY;
  logic        IMEM_DONE;
  logic        FETCH_ERR;
  logic        IMEM_ARVALID;
  logic [31:0] IMEM_ARADDR;
  logic        IMEM_ARREADY;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_RERR;

  core_ifetch dut (
    .CLK(CLK), .NRST(NRST), .PC_NEXT(PC_NEXT), .PC_WRITE(PC_WRITE), .PC(PC),
    .INSTRUCTION(INSTRUCTION), .IMEM_BUSY(IMEM_BUSY), .IMEM_DONE(IMEM_DONE),
    .FETCH_ERR(FETCH_ERR), .IMEM_ARVALID(IMEM_ARVALID), .IMEM_ARADDR(IMEM_ARADDR),
    .IMEM_ARREADY(IMEM_ARREADY), .IMEM_RVALID(IMEM_RVALID),
    .IMEM_RDATA(IMEM_RDATA), .IMEM_RERR(IMEM_RERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WI  = 32'h0050_0093;
  localparam logic [31:0] WJ  = 32'h00a0_0113;
  localparam logic [31:0] WK  = 32'h0020_8193;
  localparam logic [31:0] WL  = 32'h0000_0033;
  localparam logic [31:0] WM  = 32'h0010_0073;
  localparam logic [31:0] WN  = 32'h0030_0213;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        nrst, pcw;
    logic [31:0] pcn;
    logic        arr, rv;
    logic [31:0] rdata;
    logic        rerr;
    logic        arv;
    logic [31:0] araddr;
    logic        busy, done, err;
    logic [31:0] pc, instr;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic nrst, logic pcw, logic [31:0] pcn, logic arr,
                              logic rv, logic [31:0] rdata, logic rerr, logic arv,
                              logic [31:0] araddr, logic busy, logic done,
                              logic err, logic [31:0] pc, logic [31:0] instr);
    vec_t v;
    v = '{nrst, pcw, pcn, arr, rv, rdata, rerr, arv, araddr, busy, done, err, pc, instr};
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    NRST         = v.nrst;
    PC_WRITE     = v.pcw;
    PC_NEXT      = v.pcn;
    IMEM_ARREADY = v.arr;
    IMEM_RVALID  = v.rv;
    IMEM_RDATA   = v.rdata;
    IMEM_RERR    = v.rerr;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checks++;
    if (IMEM_ARVALID !== v.arv || IMEM_ARADDR !== v.araddr || IMEM_BUSY !== v.busy ||
        IMEM_DONE !== v.done || FETCH_ERR !== v.err || PC !== v.pc ||
        INSTRUCTION !== v.instr) begin
      failures++;
      $display("[TB] FAIL %s: got arv=%b addr=%h busy=%b done=%b err=%b pc=%h instr=%h, want arv=%b addr=%h busy=%b done=%b err=%b pc=%h instr=%h",
               name, IMEM_ARVALID, IMEM_ARADDR, IMEM_BUSY, IMEM_DONE, FETCH_ERR, PC,
               INSTRUCTION, v.arv, v.araddr, v.busy, v.done, v.err, v.pc, v.instr);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    // inputs this cycle | outputs expected during this cycle
    tbl.push_back(mk(1,0,0,0,0,0,0,       0,0,0,0,0,0,NOP));             // 0 reset values
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,0,1,0,0,0,NOP));             // 1 first ADDR
    tbl.push_back(mk(1,0,0,0,1,WI,0,      0,0,1,0,0,0,NOP));             // 2 DATA
    tbl.push_back(mk(1,1,32'h4,0,0,0,0,   0,0,0,1,0,0,WI));              // 3 DONE
    tbl.push_back(mk(1,0,0,0,0,0,0,       1,32'h4,1,0,0,32'h4,WI));      // 4 ARREADY low
    tbl.push_back(mk(1,0,0,0,0,0,0,       1,32'h4,1,0,0,32'h4,WI));      // 5
    tbl.push_back(mk(1,0,0,0,0,0,0,       1,32'h4,1,0,0,32'h4,WI));      // 6
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,32'h4,1,0,0,32'h4,WI));      // 7
    tbl.push_back(mk(1,0,0,0,1,WJ,0,      0,32'h4,1,0,0,32'h4,WI));      // 8
    tbl.push_back(mk(1,1,32'h8,0,0,0,0,   0,32'h4,0,1,0,32'h4,WJ));      // 9
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,32'h8,1,0,0,32'h8,WJ));      // 10
    tbl.push_back(mk(1,1,32'h100,0,0,0,0, 0,32'h8,1,0,0,32'h8,WJ));      // 11 redirect in DATA
    tbl.push_back(mk(1,0,0,0,1,BAD,0,     0,32'h8,1,0,0,32'h100,WJ));    // 12 stale dropped
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,32'h100,1,0,0,32'h100,WJ));  // 13
    tbl.push_back(mk(1,0,0,0,1,WK,0,      0,32'h100,1,0,0,32'h100,WJ));  // 14
    tbl.push_back(mk(1,1,32'h200,0,0,0,0, 0,32'h100,0,1,0,32'h100,WK));  // 15
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,32'h200,1,0,0,32'h200,WK));  // 16
    tbl.push_back(mk(1,1,32'h300,0,1,BAD,1, 0,32'h200,1,0,0,32'h200,WK)); // 17 redirect with RVALID
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,32'h300,1,0,0,32'h300,WK));  // 18
    tbl.push_back(mk(1,0,0,0,1,BAD,1,     0,32'h300,1,0,0,32'h300,WK));  // 19 error response
    tbl.push_back(mk(1,1,32'h305,0,0,0,0, 0,32'h300,0,1,1,32'h300,NOP)); // 20 unaligned PC_NEXT
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,32'h304,1,0,1,32'h304,NOP)); // 21
    tbl.push_back(mk(1,0,0,0,1,WL,0,      0,32'h304,1,0,1,32'h304,NOP)); // 22
    tbl.push_back(mk(1,0,0,0,1,BAD,0,     0,32'h304,0,1,0,32'h304,WL));  // 23 stray RVALID
    tbl.push_back(mk(1,1,32'h400,0,0,0,0, 0,32'h304,0,1,0,32'h304,WL));  // 24
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,32'h400,1,0,0,32'h400,WL));  // 25
    tbl.push_back(mk(0,0,0,0,0,0,0,       0,32'h400,1,0,0,32'h400,WL));  // 26 reset in DATA
    tbl.push_back(mk(1,0,0,0,1,BAD,0,     0,0,0,0,0,0,NOP));             // 27 late RVALID
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,0,1,0,0,0,NOP));             // 28
    tbl.push_back(mk(1,0,0,0,1,WI,0,      0,0,1,0,0,0,NOP));             // 29
    tbl.push_back(mk(1,1,0,0,0,0,0,       0,0,0,1,0,0,WI));              // 30 same-PC refetch
    tbl.push_back(mk(1,1,32'h500,0,0,0,0, 1,0,1,0,0,0,WI));              // 31 redirect in ADDR
    tbl.push_back(mk(1,1,32'h600,0,0,0,0, 1,0,1,0,0,32'h500,WI));        // 32 repeated redirect
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,0,1,0,0,32'h600,WI));        // 33
    tbl.push_back(mk(1,0,0,0,1,BAD,0,     0,0,1,0,0,32'h600,WI));        // 34 killed response
    tbl.push_back(mk(1,0,0,1,0,0,0,       1,32'h600,1,0,0,32'h600,WI));  // 35
    tbl.push_back(mk(1,0,0,0,1,WM,0,      0,32'h600,1,0,0,32'h600,WI));  // 36
    tbl.push_back(mk(1,0,0,0,0,0,0,       0,32'h600,0,1,0,32'h600,WM));  // 37

    applyStimulus(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    repeat (3) @(negedge CLK);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i), tbl[i]);
      @(negedge CLK);
    end

    // Zero-wait latency: redirect at edge t, ARVALID in t+1, DONE in t+3.
    applyStimulus(mk(1,1,32'h700,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge CLK);
    applyStimulus(mk(1,0,0,1,0,0,0, 0,0,0,0,0,0,0));
    checkBit("lat_arvalid_t1", IMEM_ARVALID, 1'b1);
    checkBit("lat_addr_t1", IMEM_ARADDR == 32'h700, 1'b1);
    @(negedge CLK);
    applyStimulus(mk(1,0,0,0,1,WN,0, 0,0,0,0,0,0,0));
    checkBit("lat_done_t2", IMEM_DONE, 1'b0);
    @(negedge CLK);
    applyStimulus(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    checkBit("lat_done_t3", IMEM_DONE, 1'b1);
    checkBit("lat_instr_t3", INSTRUCTION == WN, 1'b1);
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_ifetch.md
Name: core_ifetch

Overview:
Instruction-fetch stage of the pipelined RV32I core, directly upstream of the pipeline control block. Owns the architectural PC register and issues one instruction read at a time on a valid/ready instruction-memory port. Presents the fetched word as INSTRUCTION with IMEM_BUSY/IMEM_DONE status for the hazard control unit. Accepts PC redirects (sequential, jump, branch) via PC_WRITE/PC_NEXT, including mid-fetch, and discards stale responses.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word presented after reset and on fetch error (ADDI x0,x0,0)

Ports:
CLK  in  1  clock, rising edge
NRST  in  1  reset, synchronous, active-low
PC_NEXT  in  32  next PC from PC-update logic
PC_WRITE  in  1  load PC_NEXT into PC and fetch it (HCU PC write enable)
PC  out  32  address of the instruction currently held or being fetched
INSTRUCTION  out  32  last fetched instruction word, held stable between captures
IMEM_BUSY  out  1  fetch in flight (states ADDR, DATA)
IMEM_DONE  out  1  INSTRUCTION is valid for PC (state DONE)
FETCH_ERR  out  1  held instruction came from an errored response
IMEM_ARVALID  out  1  read request valid
IMEM_ARADDR  out  32  read address, word aligned
IMEM_ARREADY  in  1  memory accepts request
IMEM_RVALID  in  1  read data valid (single-cycle pulse)
IMEM_RDATA  in  32  read data
IMEM_RERR  in  1  read error, qualified by RVALID

Behaviour:
- Reset, NRST low at edge: PC=RESET_VECTOR, INSTRUCTION=NOP_INSTR, IMEM_BUSY=0, IMEM_DONE=0, FETCH_ERR=0, ARVALID=0, kill=0, state=IDLE. Reset overrides all events, including mid-transaction. Any response already in flight is ignored after reset, because kill=0 and the state is not DATA.
- States: IDLE, ADDR, DATA, DONE.
- IDLE: unconditional transition to ADDR on the next edge. This is the first fetch after reset.
- ADDR: ARVALID=1, ARADDR={PC[31:2],2'b00}. ARVALID and ARADDR stay stable until ARREADY. ARVALID&ARREADY moves to DATA.
- DATA: wait for RVALID.
  - On RVALID with kill=0: INSTRUCTION<=RERR?NOP_INSTR:RDATA, FETCH_ERR<=RERR, go to DONE.
  - On RVALID with kill=1: drop the data, clear kill, go to ADDR.
- DONE: IMEM_DONE=1. INSTRUCTION and PC are held indefinitely until PC_WRITE.
- PC_WRITE handling, in every state, at the edge: PC<=PC_NEXT with bits [1:0] forced to 0.
  - In DONE: go to ADDR. IMEM_DONE drops the following cycle.
  - In IDLE: stay on the normal path to ADDR, using the new PC.
  - In ADDR before the handshake: the request is not withdrawn. Set kill=1, complete the handshake on the old address, then discard its response.
  - In ADDR on the same cycle as ARREADY: set kill=1 and go to DATA.
  - In DATA without RVALID: set kill=1.
  - In DATA on the same cycle as RVALID: discard the response regardless of kill, clear kill, go to ADDR.
- Repeated PC_WRITE while kill=1: only the latest PC is kept. A single kill covers the one outstanding response.
- PC_WRITE with PC_NEXT==PC in DONE still refetches.
- Latency, zero-wait memory (ARREADY same cycle, RVALID next cycle): PC_WRITE at edge t gives ARVALID in cycle t+1 and IMEM_DONE in cycle t+3. Each memory wait cycle adds one cycle.
- IMEM_BUSY and IMEM_DONE are never high together. Both are low only in IDLE.
- Only one outstanding transaction at a time. RVALID outside DATA is ignored.

Decomposition:
- Shared header: state encoding constants (IF_IDLE=2'd0, IF_ADDR=2'd1, IF_DATA=2'd2, IF_DONE=2'd3), NOP encoding 32'h13, default reset vector.
- Single module, no sub-module; FSM, PC register, kill flag and instruction register are all local.

Test Plan:
- Reset then zero-wait memory returning 32'h00500093 at addr 0 → ARVALID in the 2nd cycle after reset release with ARADDR=0; IMEM_DONE=1 with INSTRUCTION=32'h00500093, PC=0.
- In DONE, PC_WRITE with PC_NEXT=32'h4, ARREADY held low 3 cycles → ARVALID/ARADDR=4 stable for all 4 cycles, IMEM_BUSY=1, IMEM_DONE=0 until data returns.
- PC_WRITE with PC_NEXT=32'h100 while in DATA for addr 8 → RDATA for addr 8 dropped (INSTRUCTION unchanged), new request ARADDR=32'h100, DONE with its word.
- PC_WRITE on the same cycle as RVALID in DATA → response discarded, next ARADDR=PC_NEXT, FETCH_ERR unchanged.
- RVALID with RERR=1 → INSTRUCTION=32'h13, FETCH_ERR=1, IMEM_DONE=1; the next clean fetch clears FETCH_ERR.
- NRST asserted while in DATA, then a late RVALID → all outputs at reset values, late RVALID ignored, fetch restarts at RESET_VECTOR.
